hrg_vram_arbiter: RTL and testbench

Shares the single-port synchronous HRG video RAM (16K x 8) between the HRG display fetch and CPU port accesses. Display fetches have absolute priority and fixed latency; CPU reads and writes fill the free slots through a req/ack handshake. It sits between the display block's HRG address/data pins, the CPU I/O decode and the HRG RAM primitive.

---
 rtl/hrg_vram_if.sv | 36 +++
 rtl/hrg_vram_arbiter.sv | 79 +++++++
 tb/tb_hrg_vram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hrg_vram_if.sv
// HRG video RAM arbiter bus: display fetch port, CPU req/ack port, RAM port and stall stats.
interface hrg_vram_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              i_disp_req;
  logic [ADDR_W-1:0] i_disp_addr;
  logic [DATA_W-1:0] o_disp_data;
  logic              o_disp_valid;
  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_ack;
  logic [ADDR_W-1:0] o_ram_addr;
  logic              o_ram_we;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;
  logic              i_stat_clear;
  logic [7:0]        o_stall_count;

  modport slave (
    input  i_disp_req, i_disp_addr, i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
           i_ram_rdata, i_stat_clear,
    output o_disp_data, o_disp_valid, o_cpu_rdata, o_cpu_ack, o_ram_addr, o_ram_we,
           o_ram_wdata, o_stall_count
  );

  modport master (
    output i_disp_req, i_disp_addr, i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
           i_ram_rdata, i_stat_clear,
    input  o_disp_data, o_disp_valid, o_cpu_rdata, o_cpu_ack, o_ram_addr, o_ram_we,
           o_ram_wdata, o_stall_count
  );
endinterface

// File: rtl/hrg_vram_arbiter.sv
// Single-port HRG VRAM arbiter: display fetch has absolute priority with fixed 3-cycle
// latency; CPU accesses fill free slots, one outstanding at a time.
module hrg_vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  hrg_vram_if.slave   bus
);
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_t;

  tag_t s1, s2;
  logic we1, we2;
  logic busy;
  logic cpu_go;

  // Blocking on the ack cycle keeps a still-held req from being issued twice.
  assign cpu_go = bus.i_cpu_req && !busy && !bus.o_cpu_ack;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1               <= TAG_NONE;
      s2               <= TAG_NONE;
      we1              <= 1'b0;
      we2              <= 1'b0;
      busy             <= 1'b0;
      bus.o_ram_addr   <= '0;
      bus.o_ram_we     <= 1'b0;
      bus.o_ram_wdata  <= '0;
      bus.o_disp_data  <= '0;
      bus.o_disp_valid <= 1'b0;
      bus.o_cpu_rdata  <= '0;
      bus.o_cpu_ack    <= 1'b0;
    end else begin
      // Grant slot (E0)
      if (bus.i_disp_req) begin
        bus.o_ram_addr <= bus.i_disp_addr;
        bus.o_ram_we   <= 1'b0;
        s1             <= TAG_DISP;
        we1            <= 1'b0;
      end else if (cpu_go) begin
        bus.o_ram_addr  <= bus.i_cpu_addr;
        bus.o_ram_we    <= bus.i_cpu_we;
        bus.o_ram_wdata <= bus.i_cpu_wdata;
        s1              <= TAG_CPU;
        we1             <= bus.i_cpu_we;
      end else begin
        bus.o_ram_we <= 1'b0;
        s1           <= TAG_NONE;
        we1          <= 1'b0;
      end

      // RAM samples the address (E1)
      s2  <= s1;
      we2 <= we1;

      // Capture RAM data and complete (E2); busy never sets and clears on the same edge
      bus.o_disp_valid <= (s2 == TAG_DISP);
      bus.o_cpu_ack    <= (s2 == TAG_CPU);
      if (s2 == TAG_DISP) bus.o_disp_data <= bus.i_ram_rdata;
      if (s2 == TAG_CPU) begin
        if (!we2) bus.o_cpu_rdata <= bus.i_ram_rdata;
        busy <= 1'b0;
      end else if (!bus.i_disp_req && cpu_go) begin
        busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      bus.o_stall_count <= '0;
    else if (bus.i_stat_clear)
      bus.o_stall_count <= '0;
    else if (bus.i_disp_req && cpu_go && bus.o_stall_count != 8'hFF)
      bus.o_stall_count <= bus.o_stall_count + 8'd1;
  end
endmodule

// File: tb/tb_hrg_vram_arbiter.sv
// Bench for hrg_vram_arbiter: RAM model plus a grant-order reference model that serialises
// memory operations and predicts fixed-latency completions.
module tb_hrg_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;

  hrg_vram_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  hrg_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + (i >> 6));
  endfunction

  // Synchronous single-port RAM, write-first
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (bus.o_ram_we) begin
      ram[bus.o_ram_addr] <= bus.o_ram_wdata;
    end
    bus.i_ram_rdata <= bus.o_ram_we ? bus.o_ram_wdata : ram[bus.o_ram_addr];
  end

  // Reference model: ops take effect in grant order, results appear 3 cycles after request
  typedef struct {int due; bit disp; bit we; logic [7:0] data;} ev_t;
  ev_t evq[$];
  logic [7:0] ref_mem [0:DEPTH-1];
  int n_edge = 0;
  bit m_busy, e_dv, e_ack;
  logic [7:0] e_dd, e_rd, e_stall;
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    evq.delete();
    m_busy = 0; e_dv = 0; e_ack = 0;
    e_dd = '0; e_rd = '0; e_stall = '0;
  endtask

  task automatic step();
    bit ok;
    ev_t ev;
    ok = bus.i_cpu_req && !m_busy && !e_ack;
    if (bus.i_disp_req) begin
      ev.due = n_edge + 2; ev.disp = 1; ev.we = 0; ev.data = ref_mem[bus.i_disp_addr];
      evq.push_back(ev);
    end else if (ok) begin
      ev.due = n_edge + 2; ev.disp = 0; ev.we = bus.i_cpu_we; ev.data = ref_mem[bus.i_cpu_addr];
      if (bus.i_cpu_we) ref_mem[bus.i_cpu_addr] = bus.i_cpu_wdata;
      m_busy = 1;
      evq.push_back(ev);
    end
    if (bus.i_stat_clear) e_stall = '0;
    else if (bus.i_disp_req && ok && e_stall != 8'd255) e_stall = e_stall + 8'd1;
    @(posedge clk);
    #1;
    e_dv = 0; e_ack = 0;
    while (evq.size() > 0 && evq[0].due == n_edge) begin
      ev = evq.pop_front();
      if (ev.disp) begin
        e_dv = 1; e_dd = ev.data;
      end else begin
        e_ack = 1; m_busy = 0;
        if (!ev.we) e_rd = ev.data;
      end
    end
    n_edge++;
  endtask

  function automatic logic [48:0] all_outs();
    return {bus.o_disp_data, bus.o_disp_valid, bus.o_cpu_rdata, bus.o_cpu_ack, bus.o_ram_addr,
            bus.o_ram_we, bus.o_ram_wdata, bus.o_stall_count};
  endfunction

  task automatic test_reset();
    bus.i_disp_req = 0; bus.i_disp_addr = '0; bus.i_cpu_req = 0; bus.i_cpu_we = 0;
    bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0; bus.i_stat_clear = 0;
    rst = 1; preload = 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    @(posedge clk); #1;
    preload = 0;
    model_reset();
    n_cmp++;
    if (all_outs() !== 49'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    rst = 0;
    bus.i_cpu_req = 1; bus.i_cpu_we = 1; bus.i_cpu_addr = 14'h2AAA; bus.i_cpu_wdata = 8'h77;
    step();
    step();
    #2 rst = 1;
    #1;
    n_cmp++;
    if (all_outs() !== 49'd0) begin
      n_err++; $display("FAIL reset_async: got %h want 0", all_outs());
    end
    model_reset();
    bus.i_cpu_req = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_cmp++;
      if ({bus.o_ram_we, bus.o_disp_valid, bus.o_cpu_ack} !== 3'b000) begin
        n_err++; $display("FAIL reset_idle c%0d: got we/valid/ack %b want 000", c,
                          {bus.o_ram_we, bus.o_disp_valid, bus.o_cpu_ack});
      end
    end
  endtask

  task automatic test_cpu_rw();
    logic [8+AW+8+8-1:0] tbl [4];
    tbl[0] = {8'd1, 14'h1234, 8'h5A, 8'h00};
    tbl[1] = {8'd0, 14'h1234, 8'h00, 8'h5A};
    tbl[2] = {8'd1, 14'h3FFF, 8'hC3, 8'h00};
    tbl[3] = {8'd0, 14'h3FFF, 8'h00, 8'hC3};
    for (int t = 0; t < 4; t++) begin
      int lat = 0, acks = 0;
      bit drop = 0;
      bus.i_cpu_we = tbl[t][8+AW+8+8-1 -: 8] != 8'd0;
      bus.i_cpu_addr = tbl[t][AW+16-1 -: AW];
      bus.i_cpu_wdata = tbl[t][15:8];
      bus.i_cpu_req = 1;
      for (int c = 1; c <= 8; c++) begin
        step();
        n_cmp++;
        if ({bus.o_cpu_ack, bus.o_cpu_rdata, bus.o_disp_valid} !== {e_ack, e_rd, e_dv}) begin
          n_err++; $display("FAIL cpu_rw t%0d c%0d: got %b/%h/%b want %b/%h/%b", t, c,
                            bus.o_cpu_ack, bus.o_cpu_rdata, bus.o_disp_valid, e_ack, e_rd, e_dv);
        end
        if (drop) begin bus.i_cpu_req = 0; drop = 0; end
        if (bus.o_cpu_ack) begin
          acks++; drop = 1;
          if (lat == 0) lat = c;
          if (!bus.i_cpu_we) begin
            n_cmp++;
            if (bus.o_cpu_rdata !== tbl[t][7:0]) begin
              n_err++; $display("FAIL cpu_rdata t%0d: got %h want %h", t, bus.o_cpu_rdata, tbl[t][7:0]);
            end
          end
        end
      end
      n_cmp++;
      if (lat != 3 || acks != 1) begin
        n_err++; $display("FAIL cpu_latency t%0d: got lat %0d acks %0d want lat 3 acks 1", t, lat, acks);
      end
    end
  endtask

  task automatic test_priority();
    int vlat = 0, alat = 0;
    bit drop = 0;
    logic [7:0] exp_d, exp_r;
    exp_d = ref_mem[14'h0100];
    exp_r = ref_mem[14'h0200];
    bus.i_disp_req = 1; bus.i_disp_addr = 14'h0100;
    bus.i_cpu_req = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 14'h0200;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.i_disp_req = 0;
      n_cmp++;
      if ({bus.o_disp_valid, bus.o_disp_data, bus.o_cpu_ack, bus.o_cpu_rdata, bus.o_stall_count} !==
          {e_dv, e_dd, e_ack, e_rd, e_stall}) begin
        n_err++; $display("FAIL priority c%0d: got v%b d%h a%b r%h s%0d want v%b d%h a%b r%h s%0d", c,
                          bus.o_disp_valid, bus.o_disp_data, bus.o_cpu_ack, bus.o_cpu_rdata,
                          bus.o_stall_count, e_dv, e_dd, e_ack, e_rd, e_stall);
      end
      if (drop) begin bus.i_cpu_req = 0; drop = 0; end
      if (bus.o_disp_valid && vlat == 0) vlat = c;
      if (bus.o_cpu_ack) begin drop = 1; if (alat == 0) alat = c; end
      if (c == 4) begin
        n_cmp++;
        if ({bus.o_disp_data, bus.o_cpu_rdata} !== {exp_d, exp_r}) begin
          n_err++; $display("FAIL priority_data: got %h/%h want %h/%h", bus.o_disp_data,
                            bus.o_cpu_rdata, exp_d, exp_r);
        end
      end
    end
    n_cmp++;
    if (vlat != 3 || alat != 4 || bus.o_stall_count !== 8'd1) begin
      n_err++; $display("FAIL priority_timing: got vlat %0d alat %0d stall %0d want 3 4 1",
                        vlat, alat, bus.o_stall_count);
    end
  endtask

  task automatic test_hazard();
    bit drop = 0;
    int vlat = 0;
    bus.i_cpu_req = 1; bus.i_cpu_we = 1; bus.i_cpu_addr = 14'h0777; bus.i_cpu_wdata = 8'hE1;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.i_disp_req = (c == 1);
      bus.i_disp_addr = 14'h0777;
      n_cmp++;
      if ({bus.o_disp_valid, bus.o_disp_data, bus.o_cpu_ack} !== {e_dv, e_dd, e_ack}) begin
        n_err++; $display("FAIL hazard c%0d: got %b/%h/%b want %b/%h/%b", c, bus.o_disp_valid,
                          bus.o_disp_data, bus.o_cpu_ack, e_dv, e_dd, e_ack);
      end
      if (drop) begin bus.i_cpu_req = 0; drop = 0; end
      if (bus.o_cpu_ack) drop = 1;
      if (bus.o_disp_valid && vlat == 0) begin
        vlat = c;
        n_cmp++;
        if (bus.o_disp_data !== 8'hE1) begin
          n_err++; $display("FAIL hazard_data: got %h want e1", bus.o_disp_data);
        end
      end
    end
    n_cmp++;
    if (vlat != 4) begin
      n_err++; $display("FAIL hazard_latency: got %0d want 4", vlat);
    end
  endtask

  task automatic test_stream();
    int issued = 0, acks = 0, dreq = 0, dval = 0;
    bit drop = 0, active;
    bus.i_cpu_req = 0;
    for (int c = 0; c < 480 * 8 + 8; c++) begin
      active = c < 480 * 8;
      bus.i_disp_req = active && (c % 8 == 0);
      bus.i_disp_addr = AW'($urandom);
      if (bus.i_disp_req) dreq++;
      if (active && !bus.i_cpu_req && $urandom_range(0, 2) == 0) begin
        bus.i_cpu_req = 1; bus.i_cpu_we = 1'($urandom);
        bus.i_cpu_addr = AW'($urandom); bus.i_cpu_wdata = 8'($urandom);
        issued++;
      end
      step();
      n_cmp++;
      if ({bus.o_disp_valid, bus.o_disp_data} !== {e_dv, e_dd}) begin
        n_err++; $display("FAIL stream_disp c%0d: got %b/%h want %b/%h", c, bus.o_disp_valid,
                          bus.o_disp_data, e_dv, e_dd);
      end
      n_cmp++;
      if ({bus.o_cpu_ack, bus.o_cpu_rdata, bus.o_stall_count} !== {e_ack, e_rd, e_stall}) begin
        n_err++; $display("FAIL stream_cpu c%0d: got %b/%h/%0d want %b/%h/%0d", c, bus.o_cpu_ack,
                          bus.o_cpu_rdata, bus.o_stall_count, e_ack, e_rd, e_stall);
      end
      if (drop) begin bus.i_cpu_req = 0; drop = 0; end
      if (bus.o_cpu_ack) begin acks++; drop = 1; end
      if (bus.o_disp_valid) dval++;
    end
    n_cmp++;
    if (acks != issued || dval != dreq) begin
      n_err++; $display("FAIL stream_counts: got acks %0d valids %0d want %0d %0d", acks, dval,
                        issued, dreq);
    end
  endtask

  task automatic test_stall();
    bit drop = 0;
    int acks = 0;
    bus.i_cpu_req = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 14'h0042;
    bus.i_stat_clear = 1; bus.i_disp_req = 0;
    step();
    bus.i_stat_clear = 0;
    for (int c = 0; c < 300; c++) begin
      bus.i_disp_req = 1; bus.i_disp_addr = AW'($urandom);
      step();
      n_cmp++;
      if ({bus.o_disp_valid, bus.o_disp_data, bus.o_stall_count, bus.o_cpu_ack} !==
          {e_dv, e_dd, e_stall, e_ack}) begin
        n_err++; $display("FAIL stall_run c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b", c,
                          bus.o_disp_valid, bus.o_disp_data, bus.o_stall_count, bus.o_cpu_ack,
                          e_dv, e_dd, e_stall, e_ack);
      end
    end
    n_cmp++;
    if (bus.o_stall_count !== 8'd255) begin
      n_err++; $display("FAIL stall_saturate: got %0d want 255", bus.o_stall_count);
    end
    bus.i_stat_clear = 1;
    step();
    bus.i_stat_clear = 0; bus.i_disp_req = 0;
    n_cmp++;
    if (bus.o_stall_count !== 8'd0) begin
      n_err++; $display("FAIL stall_clear: got %0d want 0", bus.o_stall_count);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if ({bus.o_disp_valid, bus.o_cpu_ack, bus.o_cpu_rdata} !== {e_dv, e_ack, e_rd}) begin
        n_err++; $display("FAIL stall_drain c%0d: got %b/%b/%h want %b/%b/%h", c,
                          bus.o_disp_valid, bus.o_cpu_ack, bus.o_cpu_rdata, e_dv, e_ack, e_rd);
      end
      if (drop) begin bus.i_cpu_req = 0; drop = 0; end
      if (bus.o_cpu_ack) begin acks++; drop = 1; end
    end
    n_cmp++;
    if (acks != 1) begin
      n_err++; $display("FAIL stall_ack_count: got %0d want 1", acks);
    end
  endtask

  task automatic test_reset_mid();
    bit drop = 0;
    int acks = 0, lat = 0;
    logic [7:0] exp_r;
    bus.i_cpu_req = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 14'h1234;
    exp_r = ref_mem[14'h1234];
    step();
    @(posedge clk); #1;
    rst = 1;
    bus.i_cpu_req = 0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.o_cpu_ack, bus.o_disp_valid} !== 2'b00) begin
        n_err++; $display("FAIL reset_mid_noack c%0d: got ack/valid %b want 00", c,
                          {bus.o_cpu_ack, bus.o_disp_valid});
      end
    end
    rst = 0;
    step();
    n_cmp++;
    if (bus.o_cpu_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_release: got ack %b want 0", bus.o_cpu_ack);
    end
    bus.i_cpu_req = 1;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_cmp++;
      if ({bus.o_cpu_ack, bus.o_cpu_rdata} !== {e_ack, e_rd}) begin
        n_err++; $display("FAIL reset_mid_reissue c%0d: got %b/%h want %b/%h", c, bus.o_cpu_ack,
                          bus.o_cpu_rdata, e_ack, e_rd);
      end
      if (drop) begin bus.i_cpu_req = 0; drop = 0; end
      if (bus.o_cpu_ack) begin
        acks++; drop = 1;
        if (lat == 0) lat = c;
      end
    end
    n_cmp++;
    if (acks != 1 || lat != 3 || bus.o_cpu_rdata !== exp_r) begin
      n_err++; $display("FAIL reset_mid_result: got acks %0d lat %0d data %h want 1 3 %h", acks,
                        lat, bus.o_cpu_rdata, exp_r);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_priority();
    test_hazard();
    test_stream();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
